// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : exc_ctrl_if
// Brief  : MEM-stage / CP0 write-port bundle between the pipeline and exc_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface exc_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic [6:0]  mem_exc;
  logic        mem_eret;
  logic [31:0] mem_bad_vaddr;
  logic        pipe_cp0_we;
  logic [4:0]  pipe_cp0_waddr;
  logic [31:0] pipe_cp0_wdata;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic [31:0] exc_pc;
  logic        stall;

  modport slave (
    input  mem_valid, mem_pc, mem_in_delay_slot, mem_exc, mem_eret, mem_bad_vaddr,
    input  pipe_cp0_we, pipe_cp0_waddr, pipe_cp0_wdata,
    input  cp0_status, cp0_cause, cp0_epc,
    output cp0_we, cp0_waddr, cp0_wdata, flush, exc_pc, stall
  );

  modport master (
    output mem_valid, mem_pc, mem_in_delay_slot, mem_exc, mem_eret, mem_bad_vaddr,
    output pipe_cp0_we, pipe_cp0_waddr, pipe_cp0_wdata,
    output cp0_status, cp0_cause, cp0_epc,
    input  cp0_we, cp0_waddr, cp0_wdata, flush, exc_pc, stall
  );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : exc_ctrl
// Brief  : Exception/interrupt/ERET sequencer driving the CP0 write port.
//          Optional macro EXC_BADVADDR_EN adds the BadVAddr write for AdEL/AdES.
// Rev    : 1.0  initial release
// ============================================================================
module exc_ctrl (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_W_EPC    = 3'd1;
  localparam logic [2:0] ST_W_CAUSE  = 3'd2;
`ifdef EXC_BADVADDR_EN
  localparam logic [2:0] ST_W_BADV   = 3'd3;
`endif
  localparam logic [2:0] ST_W_STATUS = 3'd4;
  localparam logic [2:0] ST_W_ERET   = 3'd5;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  logic [2:0]  state_q,  state_d;
  logic [4:0]  code_q,   code_d;
  logic        bd_q,     bd_d;
  logic [31:0] epc_q,    epc_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q,  cause_d;
`ifdef EXC_BADVADDR_EN
  logic [31:0] badv_q,   badv_d;
`endif

  logic        w_int_pend;
  logic        w_exc_any;
  logic        w_take;
  logic [4:0]  w_code;
  logic        unused_bits;

  assign w_int_pend = (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]))
                      && bus.cp0_status[0] && !bus.cp0_status[1];
  assign w_exc_any  = w_int_pend || (|bus.mem_exc);
  assign w_take     = (state_q == ST_IDLE) && bus.mem_valid && (w_exc_any || bus.mem_eret);

  // Cause bits outside [30:7] are rebuilt from captured fields, never copied.
`ifdef EXC_BADVADDR_EN
  assign unused_bits = ^{bus.cp0_cause[31], bus.cp0_cause[6:0]};
`else
  assign unused_bits = ^{bus.cp0_cause[31], bus.cp0_cause[6:0], bus.mem_bad_vaddr};
`endif

  always_comb begin
    w_code = 5'd0;
    if (w_int_pend)          w_code = 5'd0;
    else if (bus.mem_exc[0]) w_code = 5'd4;
    else if (bus.mem_exc[1]) w_code = 5'd10;
    else if (bus.mem_exc[2]) w_code = 5'd12;
    else if (bus.mem_exc[3]) w_code = 5'd8;
    else if (bus.mem_exc[4]) w_code = 5'd9;
    else if (bus.mem_exc[5]) w_code = 5'd4;
    else if (bus.mem_exc[6]) w_code = 5'd5;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= 5'd0;
      bd_q     <= 1'b0;
      epc_q    <= 32'd0;
      status_q <= 32'd0;
      cause_q  <= 32'd0;
`ifdef EXC_BADVADDR_EN
      badv_q   <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bd_q     <= bd_d;
      epc_q    <= epc_d;
      status_q <= status_d;
      cause_q  <= cause_d;
`ifdef EXC_BADVADDR_EN
      badv_q   <= badv_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    bd_d     = bd_q;
    epc_d    = epc_q;
    status_d = status_q;
    cause_d  = cause_q;
`ifdef EXC_BADVADDR_EN
    badv_d   = badv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid && w_exc_any) begin
          code_d   = w_code;
          bd_d     = bus.mem_in_delay_slot;
          epc_d    = bus.mem_in_delay_slot ? (bus.mem_pc - 32'd4) : bus.mem_pc;
          status_d = bus.cp0_status;
          cause_d  = bus.cp0_cause;
`ifdef EXC_BADVADDR_EN
          badv_d   = bus.mem_bad_vaddr;
`endif
          state_d  = ST_W_EPC;
        end else if (bus.mem_valid && bus.mem_eret) begin
          epc_d    = bus.cp0_epc;
          status_d = bus.cp0_status;
          state_d  = ST_W_ERET;
        end
      end
      ST_W_EPC:    state_d = ST_W_CAUSE;
`ifdef EXC_BADVADDR_EN
      ST_W_CAUSE:  state_d = (code_q == 5'd4 || code_q == 5'd5) ? ST_W_BADV : ST_W_STATUS;
      ST_W_BADV:   state_d = ST_W_STATUS;
`else
      ST_W_CAUSE:  state_d = ST_W_STATUS;
`endif
      ST_W_STATUS: state_d = ST_IDLE;
      ST_W_ERET:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cp0_we    = 1'b0;
    bus.cp0_waddr = 5'd0;
    bus.cp0_wdata = 32'd0;
    bus.flush     = 1'b0;
    bus.exc_pc    = 32'd0;
    bus.stall     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        // Reset holds the port quiet even though IDLE normally passes MTC0 through.
        if (!rst) begin
          bus.cp0_we    = bus.pipe_cp0_we && !w_take;
          bus.cp0_waddr = bus.pipe_cp0_waddr;
          bus.cp0_wdata = bus.pipe_cp0_wdata;
        end
      end
      ST_W_EPC: begin
        bus.flush     = 1'b1;
        bus.exc_pc    = EXC_VECTOR;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = epc_q;
      end
      ST_W_CAUSE: begin
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd13;
        bus.cp0_wdata = {bd_q, cause_q[30:7], code_q, 2'b00};
      end
`ifdef EXC_BADVADDR_EN
      ST_W_BADV: begin
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd8;
        bus.cp0_wdata = badv_q;
      end
`endif
      ST_W_STATUS: begin
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = status_q | 32'h2;
      end
      ST_W_ERET: begin
        bus.flush     = 1'b1;
        bus.exc_pc    = epc_q;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = status_q & ~32'h2;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
